// File: rtl/ldind_control_fsm_pkg.sv
// Shared definitions for the LD-indirect CPU: state encodings, opcodes,
// address-mux selects, accumulator sources and the opcode class record.
package ldind_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_LOAD_OP  = 4'd2,
        ST_LOAD_ARG = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_IND_LD   = 4'd5,
        ST_IND_RD   = 4'd6,
        ST_WB       = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_END      = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LD    = 4'h2;
    localparam logic [3:0] OP_LDIND = 4'h3;
    localparam logic [3:0] OP_ST    = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [1:0] ADDR_PC  = 2'b00;
    localparam logic [1:0] ADDR_ARG = 2'b01;
    localparam logic [1:0] ADDR_MDR = 2'b10;

    localparam logic [1:0] ACC_MEM = 2'b00;
    localparam logic [1:0] ACC_ARG = 2'b01;
    localparam logic [1:0] ACC_ALU = 2'b10;

    typedef struct packed {
        logic needs_mem;
        logic is_indirect;
        logic is_store;
        logic is_jump;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

    // Accumulator source used in the write-back cycle for a given opcode.
    function automatic logic [1:0] acc_src_for(input logic [3:0] op);
        case (op)
            OP_LDI:  return ACC_ARG;
            OP_ADD:  return ACC_ALU;
            default: return ACC_MEM;
        endcase
    endfunction

endpackage

// File: rtl/ldind_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface ldind_control_fsm_if;
    logic       run;
    logic [7:0] mem_q;
    logic [1:0] addr_sel;
    logic       pc_inc;
    logic       pc_load;
    logic       arg_load;
    logic       mdr_load;
    logic       acc_load;
    logic [1:0] acc_src;
    logic       mem_we;
    logic       halted;
    logic       illegal;
    logic [3:0] opcode;
    logic [3:0] state_dbg;

    modport master (
        input  run, mem_q,
        output addr_sel, pc_inc, pc_load, arg_load, mdr_load, acc_load,
               acc_src, mem_we, halted, illegal, opcode, state_dbg
    );

    modport slave (
        output run, mem_q,
        input  addr_sel, pc_inc, pc_load, arg_load, mdr_load, acc_load,
               acc_src, mem_we, halted, illegal, opcode, state_dbg
    );
endinterface

// File: rtl/ldind_control_fsm_opdecode.sv
// Combinational opcode-to-class decoder; NOP and LDI decode to an all-zero class.
module ldind_opdecode
    import ldind_control_fsm_pkg::*;
(
    input  logic [3:0] op,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_NOP, OP_LDI: ;
            OP_LD, OP_ADD:  cls.needs_mem = 1'b1;
            OP_LDIND: begin
                cls.needs_mem   = 1'b1;
                cls.is_indirect = 1'b1;
            end
            OP_ST:   cls.is_store   = 1'b1;
            OP_JMP:  cls.is_jump    = 1'b1;
            OP_HLT:  cls.is_halt    = 1'b1;
            default: cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ldind_control_fsm.sv
// Control sequencer for the 8-bit LD-indirect CPU: fetches opcode/operand,
// holds IR and decodes state+IR into address-mux select and datapath strobes.
module ldind_control_fsm
    import ldind_control_fsm_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    ldind_control_fsm_if.master bus
);

    state_t     state_reg;
    logic [7:0] ir_reg;
    logic       illegal_reg;
    op_class_t  cls;

    ldind_opdecode u_opdecode (
        .op  (ir_reg[7:4]),
        .cls (cls)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            ir_reg      <= 8'h00;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE:     if (bus.run) state_reg <= ST_FETCH;
                ST_FETCH:    state_reg <= ST_LOAD_OP;
                ST_LOAD_OP: begin
                    ir_reg    <= bus.mem_q;
                    state_reg <= ST_LOAD_ARG;
                end
                ST_LOAD_ARG: begin
                    if (cls.needs_mem)        state_reg <= ST_MEM_RD;
                    else if (cls.is_store)    state_reg <= ST_MEM_WR;
                    else if (cls.is_jump)     state_reg <= ST_JUMP;
                    else if (cls.is_halt)     state_reg <= ST_HALT;
                    else if (cls.is_illegal) begin
                        if (HALT_ON_ILLEGAL) begin
                            state_reg   <= ST_HALT;
                            illegal_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_END;
                        end
                    end
                    else if (ir_reg[7:4] == OP_LDI) state_reg <= ST_WB;
                    else                            state_reg <= ST_END;
                end
                ST_MEM_RD:   state_reg <= cls.is_indirect ? ST_IND_LD : ST_WB;
                ST_IND_LD:   state_reg <= ST_IND_RD;
                ST_IND_RD:   state_reg <= ST_WB;
                ST_WB:       state_reg <= ST_END;
                ST_MEM_WR:   state_reg <= ST_END;
                ST_JUMP:     state_reg <= ST_END;
                ST_END:      state_reg <= bus.run ? ST_FETCH : ST_IDLE;
                ST_HALT:     state_reg <= ST_HALT;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    // Moore decode: strobes follow the state register with no extra latency,
    // so an asynchronous reset drops them immediately.
    always_comb begin
        bus.addr_sel = ADDR_PC;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.arg_load = 1'b0;
        bus.mdr_load = 1'b0;
        bus.acc_load = 1'b0;
        bus.acc_src  = ACC_MEM;
        bus.mem_we   = 1'b0;
        bus.halted   = 1'b0;
        case (state_reg)
            ST_FETCH, ST_LOAD_OP: begin
                bus.addr_sel = ADDR_PC;
                bus.pc_inc   = 1'b1;
            end
            ST_LOAD_ARG: begin
                bus.arg_load = 1'b1;
                if (ir_reg[7:4] == OP_LDI) bus.acc_src = ACC_ARG;
            end
            ST_MEM_RD:   bus.addr_sel = ADDR_ARG;
            ST_IND_LD:   bus.mdr_load = 1'b1;
            ST_IND_RD:   bus.addr_sel = ADDR_MDR;
            ST_WB: begin
                bus.acc_load = 1'b1;
                bus.acc_src  = acc_src_for(ir_reg[7:4]);
            end
            ST_MEM_WR: begin
                bus.addr_sel = ADDR_ARG;
                bus.mem_we   = 1'b1;
            end
            ST_JUMP:     bus.pc_load = 1'b1;
            ST_HALT:     bus.halted  = 1'b1;
            default: ;
        endcase
    end

    assign bus.illegal   = illegal_reg;
    assign bus.opcode    = ir_reg[7:4];
    assign bus.state_dbg = state_reg;

endmodule

// File: tb/tb_ldind_control_fsm.sv
// Directed and random checks of the LD-indirect sequencer against a
// behavioural datapath and an instruction-level reference model.
module tb_ldind_control_fsm;
    import ldind_control_fsm_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ldind_control_fsm_if bus ();
    ldind_control_fsm_if bus0 ();

    ldind_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clock (clock), .reset (reset), .bus (bus)
    );
    ldind_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clock (clock), .reset (reset), .bus (bus0)
    );

    // Second instance sees only opcode 9 (undefined) everywhere.
    assign bus0.run   = 1'b1;
    assign bus0.mem_q = 8'h90;

    int tests = 0;
    int fails = 0;

    logic [7:0] prog [256];
    logic [7:0] mref [256];
    logic [7:0] dp_mem [256];
    logic [7:0] dp_pc, dp_arg, dp_mdr, dp_acc, mem_q_reg, dp_addr;

    // Behavioural datapath: synchronous-read memory plus PC/ARG/MDR/ACC.
    always_comb begin
        case (bus.addr_sel)
            2'b00:   dp_addr = dp_pc;
            2'b01:   dp_addr = dp_arg;
            2'b10:   dp_addr = dp_mdr;
            default: dp_addr = 8'h00;
        endcase
    end
    assign bus.mem_q = mem_q_reg;

    always @(posedge clock) begin
        if (reset) begin
            dp_pc <= 8'h00; dp_arg <= 8'h00; dp_mdr <= 8'h00;
            dp_acc <= 8'h00; mem_q_reg <= 8'h00;
            for (int i = 0; i < 256; i++) dp_mem[i] <= prog[i];
        end else begin
            mem_q_reg <= dp_mem[dp_addr];
            if (bus.mem_we) dp_mem[dp_addr] <= dp_acc;
            if (bus.pc_inc) dp_pc <= dp_pc + 8'd1;
            if (bus.pc_load) dp_pc <= dp_arg;
            if (bus.arg_load) dp_arg <= mem_q_reg;
            if (bus.mdr_load) dp_mdr <= mem_q_reg;
            if (bus.acc_load) begin
                case (bus.acc_src)
                    2'b00:   dp_acc <= mem_q_reg;
                    2'b01:   dp_acc <= dp_arg;
                    default: dp_acc <= dp_acc + mem_q_reg;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.pc_inc, bus.pc_load, bus.arg_load, bus.mdr_load,
                bus.acc_load, bus.mem_we, bus.halted};
    endfunction

    // One cycle: step to the falling edge and check the exclusivity rules.
    task automatic tick();
        @(negedge clock);
        if (!reset) begin
            check("excl_pc", 32'(bus.pc_inc & bus.pc_load), 32'd0);
            check("we_sel", 32'(bus.mem_we && bus.addr_sel != 2'b01), 32'd0);
            check("onehot_ld", 32'($countones({bus.arg_load, bus.mdr_load, bus.acc_load}) > 1), 32'd0);
            check("sel_11", 32'(bus.addr_sel == 2'b11), 32'd0);
        end
    endtask

    task automatic do_reset();
        bus.run = 1'b1;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic load_ldind();
        clear_prog();
        prog[8'h00] = 8'h31; prog[8'h01] = 8'h40;
        prog[8'h40] = 8'h55; prog[8'h55] = 8'hA7;
    endtask

    // Instruction-level model: architectural effect and cycle cost per instruction.
    task automatic isa_model(input int n, output int busy, output bit halt, output bit ill,
                             output logic [7:0] pc_o, output logic [7:0] acc_o);
        logic [7:0] mpc, macc, op, a;
        busy = 0; halt = 1'b0; ill = 1'b0; mpc = 8'h00; macc = 8'h00;
        for (int i = 0; i < 256; i++) mref[i] = prog[i];
        for (int k = 0; k < n && !halt; k++) begin
            op = mref[mpc]; a = mref[mpc + 8'd1]; mpc = mpc + 8'd2;
            case (op[7:4])
                4'h0: busy += 4;
                4'h1: begin macc = a; busy += 5; end
                4'h2: begin macc = mref[a]; busy += 6; end
                4'h3: begin macc = mref[mref[a]]; busy += 8; end
                4'h4: begin mref[a] = macc; busy += 5; end
                4'h5: begin macc = macc + mref[a]; busy += 6; end
                4'h6: begin mpc = a; busy += 5; end
                4'hF: begin halt = 1'b1; busy += 3; end
                default: begin halt = 1'b1; ill = 1'b1; busy += 3; end
            endcase
        end
        pc_o = mpc; acc_o = macc;
    endtask

    // Runs n instructions from reset, then lets the FSM park in IDLE.
    task automatic run_prog(input int n, output int busy, output bit finished);
        int done;
        busy = 0; done = 0; finished = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (bus.state_dbg == ST_HALT) begin finished = 1'b1; break; end
            if (bus.state_dbg == ST_IDLE && done == n) begin finished = 1'b1; break; end
            if (bus.state_dbg != ST_IDLE) busy++;
            if (bus.state_dbg == ST_END) begin
                done++;
                if (done == n) bus.run = 1'b0;
            end
        end
    endtask

    initial begin
        logic [1:0] src_q [$];
        int we_cnt, busy, exp_busy, bad;
        bit fin, exp_halt, exp_ill;
        logic [7:0] exp_pc, exp_acc;

        bus.run = 1'b1;
        clear_prog();

        // 1: LDIND sequence and reset values
        load_ldind();
        do_reset();
        check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_sel_src", 32'({bus.addr_sel, bus.acc_src}), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            case (c)
                1: begin check("t1_c1_state", 32'(bus.state_dbg), 32'(ST_FETCH));
                         check("t1_c1_sel", 32'(bus.addr_sel), 32'h0); end
                2: check("t1_c2_sel", 32'(bus.addr_sel), 32'h0);
                3: check("t1_c3_argld", 32'(bus.arg_load), 32'd1);
                4: check("t1_c4_sel", 32'(bus.addr_sel), 32'h1);
                5: check("t1_c5_mdr", 32'(bus.mdr_load), 32'd1);
                6: check("t1_c6_sel", 32'(bus.addr_sel), 32'h2);
                7: begin check("t1_c7_accld", 32'(bus.acc_load), 32'd1);
                         check("t1_c7_src", 32'(bus.acc_src), 32'h0);
                         check("t1_c7_memq", 32'(bus.mem_q), 32'hA7); end
                8: begin check("t1_c8_state", 32'(bus.state_dbg), 32'(ST_END));
                         check("t1_acc", 32'(dp_acc), 32'hA7);
                         check("t1_opcode", 32'(bus.opcode), 32'h3); end
                default: ;
            endcase
        end
        $display("[TB] test1 LDIND 8-cycle sequence acc=%02h", dp_acc);

        // 2: LDI 12, ADD 20, ST 30
        clear_prog();
        prog[0] = 8'h10; prog[1] = 8'h12; prog[2] = 8'h50; prog[3] = 8'h20;
        prog[4] = 8'h40; prog[5] = 8'h30; prog[8'h20] = 8'h05;
        do_reset();
        src_q.delete(); we_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.acc_load) src_q.push_back(bus.acc_src);
            if (bus.mem_we) begin
                we_cnt++;
                check("t2_we_sel", 32'(bus.addr_sel), 32'h1);
                check("t2_we_arg", 32'(dp_arg), 32'h30);
            end
            if (c == 16) check("t2_c16_state", 32'(bus.state_dbg), 32'(ST_END));
        end
        check("t2_nsrc", 32'(src_q.size()), 32'd2);
        if (src_q.size() == 2) begin
            check("t2_src0", 32'(src_q[0]), 32'h1);
            check("t2_src1", 32'(src_q[1]), 32'h2);
        end
        check("t2_we_cnt", 32'(we_cnt), 32'd1);
        check("t2_mem30", 32'(dp_mem[8'h30]), 32'h17);
        $display("[TB] test2 LDI/ADD/ST M[30]=%02h we_pulses=%0d", dp_mem[8'h30], we_cnt);

        // 3: JMP 08 then NOP at 08
        clear_prog();
        prog[0] = 8'h60; prog[1] = 8'h08;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 4) check("t3_c4_pcload", 32'(bus.pc_load), 32'd1);
            if (c == 6) begin
                check("t3_c6_state", 32'(bus.state_dbg), 32'(ST_FETCH));
                check("t3_c6_fetch", 32'({bus.addr_sel, bus.pc_inc, bus.pc_load}), 32'b0010);
                check("t3_c6_pc", 32'(dp_pc), 32'h08);
            end
        end
        $display("[TB] test3 JMP 08 pc=%02h", dp_pc);

        // 4: undefined opcode, halting instance and NOP-like instance
        clear_prog();
        prog[0] = 8'h90;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c >= 4) begin
                check("t4_halted", 32'(bus.halted), 32'd1);
                check("t4_illegal", 32'(bus.illegal), 32'd1);
            end
            if (c <= 5) check("t4_p0_illegal", 32'({bus0.illegal, bus0.halted}), 32'd0);
            if (c == 4) check("t4_p0_c4_state", 32'(bus0.state_dbg), 32'(ST_END));
            if (c == 5) check("t4_p0_c5_state", 32'(bus0.state_dbg), 32'(ST_FETCH));
        end
        $display("[TB] test4 opcode 90 halted=%0b illegal=%0b nop_variant_illegal=%0b",
                 bus.halted, bus.illegal, bus0.illegal);

        // 5: run dropped during IND_LD
        load_ldind();
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 5) begin
                check("t5_c5_state", 32'(bus.state_dbg), 32'(ST_IND_LD));
                bus.run = 1'b0;
            end
            if (c == 8) check("t5_c8_state", 32'(bus.state_dbg), 32'(ST_END));
            if (c == 9 || c == 10) begin
                check("t5_idle_state", 32'(bus.state_dbg), 32'(ST_IDLE));
                check("t5_idle_strobes", 32'({strobes(), bus.addr_sel}), 32'd0);
            end
            if (c == 10) bus.run = 1'b1;
            if (c == 11) check("t5_c11_state", 32'(bus.state_dbg), 32'(ST_FETCH));
        end
        check("t5_acc", 32'(dp_acc), 32'hA7);
        $display("[TB] test5 run drop during IND_LD acc=%02h", dp_acc);

        // 6: asynchronous reset during MEM_WR
        clear_prog();
        prog[0] = 8'h10; prog[1] = 8'h5A; prog[2] = 8'h40; prog[3] = 8'h30;
        do_reset();
        for (int c = 1; c <= 9; c++) tick();
        check("t6_c9_we", 32'(bus.mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_we", 32'(bus.mem_we), 32'd0);
        check("t6_async_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        check("t6_async_ir", 32'(bus.opcode), 32'd0);
        @(negedge clock); reset = 1'b0;
        $display("[TB] test6 async reset in MEM_WR state=%0d", bus.state_dbg);

        // Random programs against the instruction-level model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++)
                prog[i] = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
            isa_model(6, exp_busy, exp_halt, exp_ill, exp_pc, exp_acc);
            run_prog(6, busy, fin);
            check("rnd_finished", 32'(fin), 32'd1);
            check("rnd_cycles", 32'(busy), 32'(exp_busy));
            check("rnd_halt", 32'({bus.halted, bus.illegal}), 32'({exp_halt, exp_ill}));
            check("rnd_acc", 32'(dp_acc), 32'(exp_acc));
            check("rnd_pc", 32'(dp_pc), 32'(exp_pc));
            bad = 0;
            for (int i = 0; i < 256; i++) if (dp_mem[i] !== mref[i]) bad++;
            check("rnd_mem", 32'(bad), 32'd0);
            $display("[TB] random prog %0d cycles=%0d acc=%02h pc=%02h halt=%0b",
                     r, busy, dp_acc, dp_pc, bus.halted);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
